// File: rtl/rep_umul_array_if.sv
// Bus bundle for rep_umul_array: weight load, window control, bitstreams and
// the count handshake. Master drives the block, slave is the block itself.
interface rep_umul_array_if #(
    parameter int BITWIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) ();
    // Handshake: counts transfer on an edge where oValid && iReady; oValid stays
    // high and oCount stays stable until that edge, and oValid never waits on iReady.
    logic                               iLoadB;
    logic [AW-1:0]                      iBAddr;
    logic [BITWIDTH-1:0]                iB;
    logic                               iMode;
    logic                               iStart;
    logic                               iClr;
    logic [CHANNELS-1:0]                iA;
    logic [CHANNELS-1:0]                oB;
    logic [CHANNELS-1:0]                oMult;
    logic                               oBusy;
    logic                               oValid;
    logic                               iReady;
    logic [CHANNELS*(BITWIDTH+1)-1:0]   oCount;
    logic [1:0]                         oState;

    modport master (
        output iLoadB, iBAddr, iB, iMode, iStart, iClr, iA, iReady,
        input  oB, oMult, oBusy, oValid, oCount, oState
    );

    modport slave (
        input  iLoadB, iBAddr, iB, iMode, iStart, iClr, iA, iReady,
        output oB, oMult, oBusy, oValid, oCount, oState
    );
endinterface

// File: rtl/rep_umul_array.sv
// Multi-lane rate-coupled unary multiplier: per-lane van der Corput RNGs that
// advance on qualifying input bits, with a 2^BITWIDTH-cycle counting window.
module rep_umul_array #(
    parameter int BITWIDTH = 8,
    parameter int CHANNELS = 4,
    parameter int AW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic            iClk,
    input  logic            iRst,
    rep_umul_array_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic                  r_busy;
    logic                  r_valid;
    logic [BITWIDTH-1:0]   r_win;
    logic [BITWIDTH-1:0]   r_bbuf  [CHANNELS];
    logic [BITWIDTH-1:0]   r_cnt0  [CHANNELS];
    logic [BITWIDTH-1:0]   r_cnt1  [CHANNELS];
    logic [BITWIDTH:0]     r_count [CHANNELS];

    logic [CHANNELS-1:0]   w_gt0;
    logic [CHANNELS-1:0]   w_gt1;
    logic [CHANNELS-1:0]   w_mult;
    logic [CHANNELS-1:0]   w_ob;

    function automatic logic [BITWIDTH-1:0] f_bitrev(input logic [BITWIDTH-1:0] x);
        logic [BITWIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < BITWIDTH; i++) r[i] = x[BITWIDTH-1-i];
        return r;
    endfunction

    // rng1 serves A=1 bits in both modes; rng0 only serves A=0 bits in bipolar mode.
    always_comb begin
        w_gt0  = '0;
        w_gt1  = '0;
        w_mult = '0;
        w_ob   = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            w_gt0[n] = r_bbuf[n] > f_bitrev(r_cnt0[n]);
            w_gt1[n] = r_bbuf[n] > f_bitrev(r_cnt1[n]);
            if (r_mode) begin
                w_mult[n] = bus.iA[n] ? w_gt1[n] : ~w_gt0[n];
                w_ob[n]   = bus.iA[n] ? w_gt1[n] : w_gt0[n];
            end else begin
                w_mult[n] = bus.iA[n] & w_gt1[n];
                w_ob[n]   = w_gt1[n];
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_win   <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                r_bbuf[n]  <= '0;
                r_cnt0[n]  <= '0;
                r_cnt1[n]  <= '0;
                r_count[n] <= '0;
            end
        end else begin
            // RNGs keep running in every state so stream statistics span windows.
            for (int n = 0; n < CHANNELS; n++) begin
                if (bus.iClr) begin
                    r_cnt0[n] <= '0;
                    r_cnt1[n] <= '0;
                end else if (bus.iA[n]) begin
                    r_cnt1[n] <= r_cnt1[n] + 1'b1;
                end else if (r_mode) begin
                    r_cnt0[n] <= r_cnt0[n] + 1'b1;
                end
                if (bus.iLoadB && (r_state != S_RUN) && (bus.iBAddr == AW'(n)))
                    r_bbuf[n] <= bus.iB;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.iStart) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_mode  <= bus.iMode;
                        r_win   <= '0;
                        for (int n = 0; n < CHANNELS; n++) r_count[n] <= '0;
                    end
                end
                S_RUN: begin
                    for (int n = 0; n < CHANNELS; n++)
                        r_count[n] <= r_count[n] + (BITWIDTH+1)'(w_mult[n]);
                    r_win <= r_win + 1'b1;
                    if (r_win == '1) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.iReady) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign bus.oCount[g*(BITWIDTH+1) +: BITWIDTH+1] = r_count[g];
    end

    assign bus.oMult  = w_mult;
    assign bus.oB     = w_ob;
    assign bus.oBusy  = r_busy;
    assign bus.oValid = r_valid;
    assign bus.oState = r_state;
endmodule

// File: tb/tb_rep_umul_array.sv
// Bench for rep_umul_array: vector table of full windows, hand-written corner
// sequences and randomized windows, all checked against a cycle reference model.
module tb_rep_umul_array;
  localparam int BW  = 4;
  localparam int CH  = 2;
  localparam int AW  = 1;
  localparam int CW  = BW + 1;
  localparam int WIN = 1 << BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic rst3;
  always #5 clk = ~clk;

  rep_umul_array_if #(.BITWIDTH(BW), .CHANNELS(CH), .AW(AW)) bus ();
  rep_umul_array #(.BITWIDTH(BW), .CHANNELS(CH), .AW(AW)) u_dut (
    .iClk(clk), .iRst(rst), .bus(bus));

  // three-lane copy so that an address past the last lane is expressible
  rep_umul_array_if #(.BITWIDTH(BW), .CHANNELS(3), .AW(2)) bus3 ();
  rep_umul_array #(.BITWIDTH(BW), .CHANNELS(3), .AW(2)) u_dut3 (
    .iClk(clk), .iRst(rst3), .bus(bus3));

  // ---------------- reference model ----------------
  int m_b [CH];
  int m_c0[CH];
  int m_c1[CH];
  int m_cnt[CH];
  bit m_mode;
  int m_phase;   // 0 idle, 1 counting window, 2 holding result
  int m_win;

  int n_pass  = 0;
  int n_total = 0;

  function automatic int rev(int x);
    int r = 0;
    for (int i = 0; i < BW; i++) if (((x >> i) & 1) != 0) r |= 1 << (BW - 1 - i);
    return r;
  endfunction

  function automatic int m_mult(int n, int abit);
    int g1 = (m_b[n] > rev(m_c1[n])) ? 1 : 0;
    int g0 = (m_b[n] > rev(m_c0[n])) ? 1 : 0;
    if (!m_mode) return abit & g1;
    return (abit != 0) ? g1 : 1 - g0;
  endfunction

  function automatic int m_ob(int n, int abit);
    if (m_mode && abit == 0) return (m_b[n] > rev(m_c0[n])) ? 1 : 0;
    return (m_b[n] > rev(m_c1[n])) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      m_b[n] = 0; m_c0[n] = 0; m_c1[n] = 0; m_cnt[n] = 0;
    end
    m_mode = 0; m_phase = 0; m_win = 0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int cnt_of(int n);
    return int'(bus.oCount[n*CW +: CW]);
  endfunction

  // ---------------- driver ----------------
  // One clock: drive inputs, compare every output to the model, advance the model.
  task automatic cycle(input bit r, input bit load, input int addr, input int b,
                       input bit mode, input bit start, input bit clr,
                       input int a, input bit ready);
    int em, eo, mu[CH];
    @(negedge clk);
    rst = r;
    bus.iLoadB = load;
    bus.iBAddr = addr[AW-1:0];
    bus.iB     = b[BW-1:0];
    bus.iMode  = mode;
    bus.iStart = start;
    bus.iClr   = clr;
    bus.iA     = a[CH-1:0];
    bus.iReady = ready;
    #1;
    em = 0; eo = 0;
    for (int n = 0; n < CH; n++) begin
      mu[n] = m_mult(n, (a >> n) & 1);
      em |= mu[n] << n;
      eo |= m_ob(n, (a >> n) & 1) << n;
    end
    check("oMult", int'(bus.oMult), em);
    check("oB", int'(bus.oB), eo);
    check("oBusy", int'(bus.oBusy), (m_phase == 1) ? 1 : 0);
    check("oValid", int'(bus.oValid), (m_phase == 2) ? 1 : 0);
    for (int n = 0; n < CH; n++) check("oCount", cnt_of(n), m_cnt[n]);
    if (r) begin
      model_reset();
    end else begin
      if (load && m_phase != 1 && addr < CH) m_b[addr] = b;
      for (int n = 0; n < CH; n++) begin
        if (clr) begin
          m_c0[n] = 0; m_c1[n] = 0;
        end else if (((a >> n) & 1) != 0) m_c1[n] = (m_c1[n] + 1) % WIN;
        else if (m_mode) m_c0[n] = (m_c0[n] + 1) % WIN;
      end
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_mode = mode; m_win = 0;
             for (int n = 0; n < CH; n++) m_cnt[n] = 0;
           end
        1: begin
             for (int n = 0; n < CH; n++) m_cnt[n] += mu[n];
             m_win++;
             if (m_win == WIN) m_phase = 2;
           end
        default: if (ready) m_phase = 0;
      endcase
    end
  endtask

  task automatic idle(input int a);
    cycle(0, 0, 0, 0, 0, 0, 0, a, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         b0;
    int         b1;
    bit         mode;
    logic [15:0] a0;
    logic [15:0] a1;
    int         e0;
    int         e1;
  } vec_t;
  vec_t vecs[5];

  initial begin
    logic [15:0] pa0, pa1;
    int held0, held1;

    vecs[0] = '{b0: 8,  b1: 15, mode: 0, a0: 16'hFFFF, a1: 16'hFFFF, e0: 8,  e1: 15};
    vecs[1] = '{b0: 8,  b1: 0,  mode: 0, a0: 16'h5555, a1: 16'hFFFF, e0: 4,  e1: 0};
    vecs[2] = '{b0: 15, b1: 8,  mode: 1, a0: 16'h5555, a1: 16'hFFFF, e0: 8,  e1: 8};
    vecs[3] = '{b0: 0,  b1: 15, mode: 0, a0: 16'h0000, a1: 16'h0000, e0: 0,  e1: 0};
    vecs[4] = '{b0: 0,  b1: 15, mode: 1, a0: 16'h0000, a1: 16'h0000, e0: 16, e1: 1};

    rst = 1'b1; rst3 = 1'b1;
    bus.iLoadB = 0; bus.iBAddr = '0; bus.iB = '0; bus.iMode = 0;
    bus.iStart = 0; bus.iClr = 0; bus.iA = '0; bus.iReady = 0;
    bus3.iLoadB = 0; bus3.iBAddr = '0; bus3.iB = '0; bus3.iMode = 0;
    bus3.iStart = 0; bus3.iClr = 0; bus3.iA = '0; bus3.iReady = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", int'(bus.oBusy), 0);
    check("reset_valid", int'(bus.oValid), 0);
    check("reset_count", int'(bus.oCount), 0);
    check("reset_mult", int'(bus.oMult), 0);

    // table: load weights, clear RNGs with the start, run the window, check counts
    for (int v = 0; v < 5; v++) begin
      cycle(0, 1, 0, vecs[v].b0, 0, 0, 0, 0, 0);
      cycle(0, 1, 1, vecs[v].b1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, vecs[v].mode, 1, 1, 0, 0);
      pa0 = vecs[v].a0; pa1 = vecs[v].a1;
      for (int k = 0; k < WIN; k++)
        cycle(0, 0, 0, 0, 0, 0, 0, {30'd0, pa1[k], pa0[k]}, 0);
      settle();
      check($sformatf("vec%0d_valid", v), int'(bus.oValid), 1);
      check($sformatf("vec%0d_count0", v), cnt_of(0), vecs[v].e0);
      check($sformatf("vec%0d_count1", v), cnt_of(1), vecs[v].e1);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    end

    // result held under back-pressure, start in DONE ignored, start+ready dropped
    cycle(0, 1, 0, 8, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 15, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 3, 0);
    for (int k = 0; k < WIN; k++) cycle(0, 0, 0, 0, 0, 0, 0, 3, 0);
    settle();
    held0 = cnt_of(0); held1 = cnt_of(1);
    check("hold_count0", held0, 8);
    check("hold_count1", held1, 15);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 0, 0, 0, 1, 1, 0, 3, 0);
      settle();
      check("hold_valid", int'(bus.oValid), 1);
      check("hold_stable0", cnt_of(0), 8);
      check("hold_stable1", cnt_of(1), 15);
    end
    cycle(0, 0, 0, 0, 1, 1, 0, 0, 1);
    settle();
    check("handshake_valid", int'(bus.oValid), 0);
    check("start_dropped_busy", int'(bus.oBusy), 0);
    check("idle_keeps_count0", cnt_of(0), 8);
    idle(0);
    settle();
    check("still_idle_busy", int'(bus.oBusy), 0);

    // weight load during RUN is ignored
    cycle(0, 1, 0, 8, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 1, 0);
    for (int k = 0; k < WIN; k++)
      cycle(0, (k == 3), 0, 0, 0, 0, 0, 1, 0);
    settle();
    check("run_load_ignored", cnt_of(0), 8);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // iClr in IDLE restarts the sequence: rng1=0 then rev(1)=8 against B0=8
    idle(1); idle(1); idle(1);
    cycle(0, 0, 0, 0, 0, 0, 1, 1, 0);
    settle();
    check("clr_rng0_mult", int'(bus.oMult[0]), 1);
    idle(1);
    settle();
    check("clr_rng1_mult", int'(bus.oMult[0]), 0);

    // reset in the middle of a window
    cycle(0, 1, 0, 8, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 15, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 1, 3, 0);
    for (int k = 0; k < 7; k++) cycle(0, 0, 0, 0, 0, 0, 0, 3, 0);
    settle();
    check("pre_rst_busy", int'(bus.oBusy), 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 3, 0);
    settle();
    check("rst_busy", int'(bus.oBusy), 0);
    check("rst_valid", int'(bus.oValid), 0);
    check("rst_count", int'(bus.oCount), 0);
    idle(0);
    settle();
    check("rst_weights_ob", int'(bus.oB), 0);

    // randomized windows, with random clears and ignored load attempts
    for (int r = 0; r < 6; r++) begin
      int na, nr;
      na = $urandom_range(0, 6);
      for (int k = 0; k < na; k++) idle($urandom_range(0, 3));
      cycle(0, 1, 0, $urandom_range(0, WIN - 1), 0, 0, 0, $urandom_range(0, 3), 0);
      cycle(0, 1, 1, $urandom_range(0, WIN - 1), 0, 0, 0, $urandom_range(0, 3), 0);
      cycle(0, 0, 0, 0, $urandom_range(0, 1), 1, $urandom_range(0, 1),
            $urandom_range(0, 3), 0);
      for (int k = 0; k < WIN; k++)
        cycle(0, ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
              $urandom_range(0, WIN - 1), $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 0);
      nr = $urandom_range(0, 3);
      for (int k = 0; k < nr; k++) cycle(0, 0, 0, 0, 0, 1, 0, $urandom_range(0, 3), 0);
      cycle(0, 0, 0, 0, 0, 0, 0, $urandom_range(0, 3), 1);
    end

    // out-of-range weight address on the three-lane copy
    @(negedge clk);
    rst3 = 1'b0;
    bus3.iLoadB = 1; bus3.iBAddr = 2'd3; bus3.iB = 4'd15;
    @(negedge clk);
    bus3.iLoadB = 0;
    #1;
    check("addr3_no_write", int'(bus3.oB), 0);
    @(negedge clk);
    bus3.iLoadB = 1; bus3.iBAddr = 2'd2; bus3.iB = 4'd15;
    @(negedge clk);
    bus3.iLoadB = 0;
    #1;
    check("addr2_write", int'(bus3.oB), 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
